// File: rtl/wordle_guess_ctrl.sv
// wordle_guess_ctrl: Wordle game controller.
// Handles letter entry from button pulses into a ROWS x 5 board and scores
// each submitted guess against a latched target word. Scoring runs a green
// pass and then a yellow pass, one column per cycle. A registered read port
// serves the renderer.
// Optional feature: define WORDLE_HARD_MODE_EN to enable hard mode. A guess
// that changes a column that was green in the last scored row is then
// rejected.
module wordle_guess_ctrl #(
  parameter int ROWS = 6
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        new_game,
  input  logic [24:0] target_word,
  input  logic        inc_p,
  input  logic        dec_p,
  input  logic        ok_p,
  input  logic        del_p,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [4:0]  rd_letter,
  output logic [1:0]  rd_status,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic [4:0]  cur_letter,
  output logic        busy,
  output logic        game_won,
  output logic        game_lost,
  output logic        reject
);

  localparam int         COLS     = 5;
  localparam logic [3:0] ROWS_LIM = 4'(ROWS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] COL_FULL = 3'(COLS);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    SCORE_G = 3'd1,
    SCORE_Y = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_r;
  logic [4:0]  letters_r [ROWS][COLS];
  logic [1:0]  status_r  [ROWS][COLS];
  logic [4:0]  target_r  [COLS];
  logic [2:0]  idx_r;
  logic [4:0]  green_r;
  logic [4:0]  yellow_r;
  logic [4:0]  used_r;

  logic [4:0]  guess_s;
  logic [4:0]  match_s;
  logic        yhit_s;
  logic [2:0]  yidx_s;
  logic [2:0]  prev_col_s;
  logic        rd_hit_s;

`ifdef WORDLE_HARD_MODE_EN
  logic [4:0]  hard_mask_r;
  logic [4:0]  hard_letters_r [COLS];
  logic        reject_r;
  logic [4:0]  viol_vec_s;
  logic        hard_viol_s;
`endif

  // Guess letter under scoring and the lowest unused target column matching it
  always_comb begin
    guess_s    = letters_r[cur_row][idx_r];
    prev_col_s = cur_col - 3'd1;
    match_s    = 5'd0;
    for (int j = 0; j < COLS; j++) begin
      match_s[j] = !used_r[j] && (target_r[j] == guess_s);
    end
    yhit_s = |match_s;
    casez (match_s)
      5'b????1: yidx_s = 3'd0;
      5'b???10: yidx_s = 3'd1;
      5'b??100: yidx_s = 3'd2;
      5'b?1000: yidx_s = 3'd3;
      5'b10000: yidx_s = 3'd4;
      default:  yidx_s = 3'd0;
    endcase
    rd_hit_s = ({1'b0, rd_row} < ROWS_LIM) && (rd_col < COL_FULL);
  end

`ifdef WORDLE_HARD_MODE_EN
  // Hard mode: flag any previously green column whose letter has changed
  always_comb begin
    viol_vec_s = 5'd0;
    for (int c = 0; c < COLS; c++) begin
      viol_vec_s[c] = hard_mask_r[c] && (letters_r[cur_row][c] != hard_letters_r[c]);
    end
    hard_viol_s = |viol_vec_s;
  end

  assign reject = reject_r;
`else
  assign reject = 1'b0;
`endif

  // Main controller: entry cursor, board writes, scoring passes and game flags
  always_ff @(posedge ClkPort) begin
    if (Reset || new_game) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          letters_r[r][c] <= 5'd0;
          status_r[r][c]  <= 2'd0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        target_r[c] <= Reset ? 5'd0 : target_word[c*5 +: 5];
      end
      state_r    <= ENTRY;
      cur_row    <= 3'd0;
      cur_col    <= 3'd0;
      cur_letter <= 5'd0;
      busy       <= 1'b0;
      game_won   <= 1'b0;
      game_lost  <= 1'b0;
      idx_r      <= 3'd0;
      green_r    <= 5'd0;
      yellow_r   <= 5'd0;
      used_r     <= 5'd0;
`ifdef WORDLE_HARD_MODE_EN
      hard_mask_r <= 5'd0;
      reject_r    <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        hard_letters_r[c] <= 5'd0;
      end
`endif
    end else begin
`ifdef WORDLE_HARD_MODE_EN
      reject_r <= 1'b0;
`endif
      case (state_r)
        ENTRY: begin
          if (ok_p) begin
            if (cur_col < COL_FULL) begin
              letters_r[cur_row][cur_col] <= cur_letter;
              cur_col <= cur_col + 3'd1;
            end else begin
`ifdef WORDLE_HARD_MODE_EN
              if (hard_viol_s) begin
                reject_r <= 1'b1;
              end else begin
                state_r  <= SCORE_G;
                idx_r    <= 3'd0;
                green_r  <= 5'd0;
                yellow_r <= 5'd0;
                used_r   <= 5'd0;
                busy     <= 1'b1;
              end
`else
              state_r  <= SCORE_G;
              idx_r    <= 3'd0;
              green_r  <= 5'd0;
              yellow_r <= 5'd0;
              used_r   <= 5'd0;
              busy     <= 1'b1;
`endif
            end
          end else if (del_p) begin
            // Deleting at column 0 is swallowed rather than passed to inc/dec
            if (cur_col != 3'd0) begin
              cur_col    <= prev_col_s;
              cur_letter <= letters_r[cur_row][prev_col_s];
              letters_r[cur_row][prev_col_s] <= 5'd0;
            end
          end else if (inc_p) begin
            cur_letter <= (cur_letter == 5'd25) ? 5'd0 : cur_letter + 5'd1;
          end else if (dec_p) begin
            cur_letter <= (cur_letter == 5'd0) ? 5'd25 : cur_letter - 5'd1;
          end
        end
        SCORE_G: begin
          if (guess_s == target_r[idx_r]) begin
            green_r[idx_r] <= 1'b1;
            used_r[idx_r]  <= 1'b1;
          end
          if (idx_r == LAST_COL) begin
            state_r <= SCORE_Y;
            idx_r   <= 3'd0;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        SCORE_Y: begin
          if (!green_r[idx_r] && yhit_s) begin
            yellow_r[idx_r] <= 1'b1;
            used_r[yidx_s]  <= 1'b1;
          end
          if (idx_r == LAST_COL) begin
            state_r <= WRITE;
            idx_r   <= 3'd0;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        WRITE: begin
          for (int c = 0; c < COLS; c++) begin
            status_r[cur_row][c] <= green_r[c] ? 2'd3 : (yellow_r[c] ? 2'd2 : 2'd1);
          end
`ifdef WORDLE_HARD_MODE_EN
          hard_mask_r <= green_r;
          for (int c = 0; c < COLS; c++) begin
            hard_letters_r[c] <= letters_r[cur_row][c];
          end
`endif
          busy <= 1'b0;
          if (green_r == 5'h1f) begin
            game_won <= 1'b1;
            state_r  <= DONE;
          end else if (cur_row == LAST_ROW) begin
            game_lost <= 1'b1;
            state_r   <= DONE;
          end else begin
            cur_row    <= cur_row + 3'd1;
            cur_col    <= 3'd0;
            cur_letter <= 5'd0;
            state_r    <= ENTRY;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= ENTRY;
        end
      endcase
    end
  end

  // Registered board read port; out-of-range addresses read as empty
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      rd_letter <= 5'd0;
      rd_status <= 2'd0;
    end else if (rd_hit_s) begin
      rd_letter <= letters_r[rd_row][rd_col];
      rd_status <= status_r[rd_row][rd_col];
    end else begin
      rd_letter <= 5'd0;
      rd_status <= 2'd0;
    end
  end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Self-checking bench for wordle_guess_ctrl: directed Wordle scenarios plus
// randomized games, compared against a game-level reference model.
`timescale 1ns/1ps
module tb_wordle_guess_ctrl;

  logic        ClkPort = 1'b0;
  logic        Reset, new_game, inc_p, dec_p, ok_p, del_p;
  logic [24:0] target_word;
  logic [2:0]  rd_row, rd_col;
  logic [4:0]  rd_letter, cur_letter;
  logic [1:0]  rd_status;
  logic [2:0]  cur_row, cur_col;
  logic        busy, game_won, game_lost, reject;

  wordle_guess_ctrl dut (
    .ClkPort(ClkPort), .Reset(Reset), .new_game(new_game), .target_word(target_word),
    .inc_p(inc_p), .dec_p(dec_p), .ok_p(ok_p), .del_p(del_p),
    .rd_row(rd_row), .rd_col(rd_col), .rd_letter(rd_letter), .rd_status(rd_status),
    .cur_row(cur_row), .cur_col(cur_col), .cur_letter(cur_letter),
    .busy(busy), .game_won(game_won), .game_lost(game_lost), .reject(reject)
  );

  always #5 ClkPort = ~ClkPort;

  // Reference model: game state at the level of the rules
  int n_checks = 0;
  int n_fail   = 0;
  int m_let [6][5];
  int m_st  [6][5];
  int m_tgt [5];
  int m_row, m_col, m_letter;
  bit m_won, m_lost;
  int m_hmask [5];
  int m_hlet  [5];
  int m_guess [5];
  int m_res   [5];

  task automatic check_value(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  function automatic logic [24:0] w5(input int a, input int b, input int c, input int d, input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic model_clear(input logic [24:0] tw);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) begin
        m_let[r][c] = 0;
        m_st[r][c]  = 0;
      end
    for (int c = 0; c < 5; c++) begin
      m_tgt[c]   = int'(tw[c*5 +: 5]);
      m_hmask[c] = 0;
      m_hlet[c]  = 0;
    end
    m_row = 0; m_col = 0; m_letter = 0; m_won = 0; m_lost = 0;
  endtask

  // Standard Wordle: greens first, then yellows drawn from leftover target letters
  task automatic wordle_score();
    int cnt [32];
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_guess[c] == m_tgt[c]) m_res[c] = 3;
      else begin
        m_res[c] = 0;
        cnt[m_tgt[c]]++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      if (m_res[c] != 3) begin
        if (cnt[m_guess[c]] > 0) begin
          m_res[c] = 2;
          cnt[m_guess[c]]--;
        end else m_res[c] = 1;
      end
    end
  endtask

  task automatic check_cursor(input string tag, input int exp_busy, input int exp_rej);
    check_value({tag, "_row"}, cur_row, m_row);
    check_value({tag, "_col"}, cur_col, m_col);
    check_value({tag, "_letter"}, cur_letter, m_letter);
    check_value({tag, "_busy"}, busy, exp_busy);
    check_value({tag, "_won"}, game_won, int'(m_won));
    check_value({tag, "_lost"}, game_lost, int'(m_lost));
    check_value({tag, "_reject"}, reject, exp_rej);
  endtask

  task automatic read_cell(input int r, input int c);
    int el, es;
    rd_row = 3'(r);
    rd_col = 3'(c);
    tick();
    el = (r < 6 && c < 5) ? m_let[r][c] : 0;
    es = (r < 6 && c < 5) ? m_st[r][c] : 0;
    check_value("rd_letter", rd_letter, el);
    check_value("rd_status", rd_status, es);
  endtask

  task automatic sweep_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) read_cell(r, c);
  endtask

  task automatic expect_row(input int r, input logic [9:0] st);
    logic [9:0] s;
    s = st;
    for (int c = 0; c < 5; c++) begin
      rd_row = 3'(r);
      rd_col = 3'(c);
      tick();
      check_value("row_status", rd_status, int'(s[c*2 +: 2]));
    end
  endtask

  task automatic do_new_game(input logic [24:0] tw);
    new_game = 1'b1;
    target_word = tw;
    tick();
    new_game = 1'b0;
    target_word = 25'($urandom);
    model_clear(tw);
    check_cursor("new_game", 0, 0);
  endtask

  task automatic score_flow();
    int srow;
    bit all_green;
    check_value("busy_start", busy, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_value("busy_mid", busy, 1);
      check_value("won_mid", game_won, 0);
    end
    tick();
    srow = m_row;
    for (int c = 0; c < 5; c++) m_guess[c] = m_let[m_row][c];
    wordle_score();
    all_green = 1;
    for (int c = 0; c < 5; c++) begin
      m_st[m_row][c] = m_res[c];
      m_hmask[c] = (m_res[c] == 3) ? 1 : 0;
      m_hlet[c]  = m_guess[c];
      if (m_res[c] != 3) all_green = 0;
    end
    if (all_green) m_won = 1;
    else if (m_row == 5) m_lost = 1;
    else begin
      m_row++;
      m_col = 0;
      m_letter = 0;
    end
    check_cursor("scored", 0, 0);
    for (int c = 0; c < 5; c++) read_cell(srow, c);
  endtask

  task automatic press(input bit o, input bit d, input bit i, input bit dd);
    bit done, sub, viol;
    done = m_won || m_lost;
    sub  = !done && o && (m_col == 5);
    viol = 0;
`ifdef WORDLE_HARD_MODE_EN
    if (sub)
      for (int c = 0; c < 5; c++)
        if (m_hmask[c] != 0 && m_let[m_row][c] != m_hlet[c]) viol = 1;
`endif
    ok_p = o; del_p = d; inc_p = i; dec_p = dd;
    tick();
    ok_p = 0; del_p = 0; inc_p = 0; dec_p = 0;
    if (sub && !viol) score_flow();
    else if (viol) begin
      check_cursor("reject_pulse", 0, 1);
      tick();
      check_cursor("reject_end", 0, 0);
    end else begin
      if (!done) begin
        if (o) begin
          m_let[m_row][m_col] = m_letter;
          m_col++;
        end else if (d) begin
          if (m_col > 0) begin
            m_col--;
            m_letter = m_let[m_row][m_col];
            m_let[m_row][m_col] = 0;
          end
        end else if (i) m_letter = (m_letter + 1) % 26;
        else if (dd) m_letter = (m_letter + 25) % 26;
      end
      check_cursor("press", 0, 0);
    end
  endtask

  task automatic enter_letter(input int l);
    int up;
    up = (l - m_letter + 26) % 26;
    if (up <= 13) repeat (up) press(0, 0, 1, 1'($urandom_range(0, 1)));
    else repeat (26 - up) press(0, 0, 0, 1);
    press(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic enter_word(input logic [24:0] w);
    for (int c = 0; c < 5; c++) enter_letter(int'(w[c*5 +: 5]));
  endtask

  task automatic gen_guess(input bit want_win, output logic [24:0] w);
    int g [5];
    bit ok25, same;
    int fix;
    ok25 = 1;
    for (int c = 0; c < 5; c++) if (m_tgt[c] > 25) ok25 = 0;
    for (int c = 0; c < 5; c++) begin
      if (want_win && ok25) g[c] = m_tgt[c];
      else if ($urandom_range(0, 1) == 1 && m_tgt[$urandom_range(0, 4)] <= 25) g[c] = m_tgt[$urandom_range(0, 4)] % 26;
      else g[c] = $urandom_range(0, 25);
    end
`ifdef WORDLE_HARD_MODE_EN
    for (int c = 0; c < 5; c++) if (m_hmask[c] != 0) g[c] = m_hlet[c];
`endif
    if (!want_win) begin
      same = 1;
      fix  = -1;
      for (int c = 0; c < 5; c++) begin
        if (g[c] != m_tgt[c]) same = 0;
        if (m_hmask[c] == 0 && fix < 0) fix = c;
      end
      if (same && fix >= 0) g[fix] = (g[fix] + 1) % 26;
    end
    w = w5(g[0], g[1], g[2], g[3], g[4]);
  endtask

  initial begin
    logic [24:0] crane, speed, gw, tw;
    crane = w5(2, 17, 0, 13, 4);
    speed = w5(18, 15, 4, 4, 3);
    Reset = 1'b1; new_game = 1'b0; target_word = 25'd0;
    inc_p = 0; dec_p = 0; ok_p = 0; del_p = 0; rd_row = 3'd0; rd_col = 3'd0;
    tick(); tick();
    Reset = 1'b0;
    model_clear(25'd0);
    check_cursor("reset", 0, 0);
    check_value("reset_rd_letter", rd_letter, 0);
    check_value("reset_rd_status", rd_status, 0);

    // Reset leaves target AAAAA
    enter_word(25'd0);
    press(1, 0, 0, 0);
    check_value("reset_target_won", game_won, 1);

    // Cursor boundaries
    do_new_game(crane);
    press(0, 0, 0, 1);
    check_value("dec_wrap", cur_letter, 25);
    press(0, 0, 1, 0);
    check_value("inc_wrap", cur_letter, 0);
    press(0, 1, 0, 0);
    check_value("del_col0", cur_col, 0);
    repeat (5) press(0, 0, 1, 0);
    press(1, 0, 1, 0);
    check_value("ok_inc_col", cur_col, 1);
    check_value("ok_inc_letter", cur_letter, 5);
    press(0, 1, 0, 0);
    rd_row = 3'd0; rd_col = 3'd0;
    press(1, 0, 0, 0);
    check_value("rd_old_value", rd_letter, 0);
    tick();
    check_value("rd_new_value", rd_letter, 5);
    press(0, 1, 0, 0);
    enter_letter(2);
    enter_letter(17);
    press(0, 1, 0, 0);
    check_value("del_cr_col", cur_col, 1);
    check_value("del_cr_letter", cur_letter, 17);
    enter_letter(17); enter_letter(0); enter_letter(13); enter_letter(4);
    press(1, 0, 0, 0);
    check_value("crane_won", game_won, 1);
    check_value("crane_row", cur_row, 0);
    expect_row(0, {2'd3, 2'd3, 2'd3, 2'd3, 2'd3});
    press(0, 0, 1, 0);
    check_value("done_inc_ignored", cur_letter, 4);

    // SPEED vs EERIE and CRANE vs AAAAA
    do_new_game(speed);
    enter_word(w5(4, 4, 17, 8, 4));
    press(1, 0, 0, 0);
    expect_row(0, {2'd1, 2'd1, 2'd1, 2'd2, 2'd2});
    check_value("eerie_row", cur_row, 1);
    check_value("eerie_col", cur_col, 0);
    do_new_game(crane);
    enter_word(25'd0);
    press(1, 0, 0, 0);
    expect_row(0, {2'd1, 2'd1, 2'd3, 2'd1, 2'd1});

    // Six wrong guesses
    do_new_game(crane);
    for (int q = 0; q < 6; q++) begin
      gen_guess(0, gw);
      enter_word(gw);
      press(1, 0, 0, 0);
    end
    check_value("lost_flag", game_lost, 1);
    check_value("lost_won", game_won, 0);
    press(0, 0, 1, 0); press(0, 0, 0, 1); press(0, 1, 0, 0); press(1, 0, 0, 0);

    // new_game aborting a score in progress
    do_new_game(crane);
    enter_word(crane);
    ok_p = 1'b1;
    tick();
    ok_p = 1'b0;
    check_value("abort_busy_n1", busy, 1);
    repeat (3) begin
      tick();
      check_value("abort_busy", busy, 1);
    end
    do_new_game(speed);
    check_value("abort_busy_off", busy, 0);
    sweep_board();
    enter_word(crane);
    press(1, 0, 0, 0);
    check_value("abort_not_won", game_won, 0);
    enter_word(speed);
    press(1, 0, 0, 0);
    check_value("abort_new_target_won", game_won, 1);

`ifdef WORDLE_HARD_MODE_EN
    do_new_game(crane);
    enter_word(w5(2, 23, 23, 23, 23));
    press(1, 0, 0, 0);
    expect_row(0, {2'd1, 2'd1, 2'd1, 2'd1, 2'd3});
    enter_word(w5(1, 23, 23, 23, 23));
    press(1, 0, 0, 0);
    check_value("hard_row", cur_row, 1);
    check_value("hard_col", cur_col, 5);
    repeat (5) press(0, 1, 0, 0);
    enter_word(crane);
    press(1, 0, 0, 0);
    check_value("hard_won", game_won, 1);
`endif

    // Randomized games
    for (int g = 0; g < 6; g++) begin
      for (int c = 0; c < 5; c++)
        tw[c*5 +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      do_new_game(tw);
      for (int q = 0; q < 6 && !(m_won || m_lost); q++) begin
        gen_guess($urandom_range(0, 4) == 0, gw);
        enter_word(gw);
        press(1, 0, 0, 0);
      end
      repeat (4) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      sweep_board();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
